// File: rtl/disp_pkg.sv
// Shared constants for the disparity serializer: lane/word geometry, flag bit
// positions and lane indices.
package disp_pkg;

   localparam int DWIDTH_DEF = 7;
   localparam int NUM_LANES  = 3;
   localparam int LANE_W     = DWIDTH_DEF + 2;
   localparam int WORD_W     = NUM_LANES * LANE_W;
   localparam int MIS        = DWIDTH_DEF + 1;
   localparam int OCC        = DWIDTH_DEF;

   typedef enum logic [1:0] {
      LANE_45  = 2'd0,
      LANE_90  = 2'd1,
      LANE_135 = 2'd2
   } lane_e;

   function automatic int lane_w(input int dw);
      return dw + 2;
   endfunction

   function automatic int mis_bit(input int dw);
      return dw + 1;
   endfunction

   function automatic int occ_bit(input int dw);
      return dw;
   endfunction

   function automatic lane_e lane_next(input lane_e l);
      return (l == LANE_135) ? LANE_45 : lane_e'(l + 2'd1);
   endfunction

endpackage

// File: rtl/disp_word_fifo.sv
// Two-entry word FIFO with synchronous reset; push/pop are ignored when they
// would overflow or underflow.
module disp_word_fifo #(
   parameter int WIDTH = 27
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] wdata_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);

   logic [WIDTH-1:0] mem_q [2];
   logic             wptr_q, rptr_q;
   logic [1:0]       cnt_q, cnt_d;
   logic             push_ok, pop_ok;

   assign full_o  = (cnt_q == 2'd2);
   assign empty_o = (cnt_q == 2'd0);
   assign push_ok = push_i && !full_o;
   assign pop_ok  = pop_i && !empty_o;
   assign rdata_o = mem_q[rptr_q];

   always_comb begin
      cnt_d = cnt_q;
      case ({push_ok, pop_ok})
         2'b10:   cnt_d = cnt_q + 2'd1;
         2'b01:   cnt_d = cnt_q - 2'd1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < 2; i++) mem_q[i] <= '0;
         wptr_q <= 1'b0;
         rptr_q <= 1'b0;
         cnt_q  <= 2'd0;
      end else begin
         if (push_ok) begin
            mem_q[wptr_q] <= wdata_i;
            wptr_q        <= ~wptr_q;
         end
         if (pop_ok) rptr_q <= ~rptr_q;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/disp_serializer.sv
// Buffers 3-lane disparity words and emits them one lane per beat (45, 90, 135).
// Optional invalid-lane statistics counter enabled by macro DISP_SER_STATS_EN.
module disp_serializer
   import disp_pkg::*;
#(
   parameter int DWIDTH = DWIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clken,
   input  logic [3*DWIDTH+5:0]   din_overall,
   input  logic                  din_valid,
   output logic                  din_ready,
   output logic [DWIDTH+1:0]     dout,
   output logic [1:0]            dout_lane,
   output logic                  dout_last,
   output logic                  dout_invalid,
   output logic                  dout_valid,
   input  logic                  dout_ready
`ifdef DISP_SER_STATS_EN
   ,
   input  logic                  stat_clr,
   output logic [15:0]           stat_invalid_cnt
`endif
);

   localparam int LW    = lane_w(DWIDTH);
   localparam int WW    = NUM_LANES * LW;
   localparam int MIS_B = mis_bit(DWIDTH);
   localparam int OCC_B = occ_bit(DWIDTH);

   logic [WW-1:0] head;
   logic [LW-1:0] lane_sel;
   logic          full, empty;
   logic          push, beat, pop;
   lane_e         lane_q, lane_d;

   // Handshakes depend only on FIFO state, so no input reaches din_ready.
   assign din_ready  = !full;
   assign dout_valid = !empty;
   assign push       = clken && din_valid && !full;
   assign beat       = clken && !empty && dout_ready;
   assign pop        = beat && (lane_q == LANE_135);

   disp_word_fifo #(
      .WIDTH (WW)
   ) u_fifo (
      .clk_i   (clk),
      .rst_i   (rst),
      .push_i  (push),
      .pop_i   (pop),
      .wdata_i (din_overall),
      .rdata_o (head),
      .full_o  (full),
      .empty_o (empty)
   );

   always_comb begin
      lane_d = lane_q;
      if (beat) lane_d = lane_next(lane_q);
   end

   always_ff @(posedge clk) begin
      if (rst)        lane_q <= LANE_45;
      else if (clken) lane_q <= lane_d;
   end

   always_comb begin
      lane_sel = '0;
      case (lane_q)
         LANE_45:  lane_sel = head[0 +: LW];
         LANE_90:  lane_sel = head[LW +: LW];
         LANE_135: lane_sel = head[2*LW +: LW];
         default:  lane_sel = '0;
      endcase
   end

   // Stale FIFO contents are masked so an idle output reads as zero.
   assign dout         = dout_valid ? lane_sel : '0;
   assign dout_lane    = lane_q;
   assign dout_last    = (lane_q == LANE_135);
   assign dout_invalid = dout[MIS_B] | dout[OCC_B];

`ifdef DISP_SER_STATS_EN
   logic [15:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (stat_clr)
         cnt_d = '0;
      else if (beat && dout_invalid && (cnt_q != 16'hFFFF))
         cnt_d = cnt_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (rst)        cnt_q <= '0;
      else if (clken) cnt_q <= cnt_d;
   end

   assign stat_invalid_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_disp_serializer.sv
// Directed bench for disp_serializer: queue-of-words reference model checked
// every cycle, plus literal expectations for the key scenarios.
module tb_disp_serializer;

   localparam int DW = 7;
   localparam int LW = DW + 2;
   localparam int WW = 3 * LW;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          clken = 1'b1;
   logic [WW-1:0] din_overall = '0;
   logic          din_valid = 1'b0;
   logic          din_ready;
   logic [LW-1:0] dout;
   logic [1:0]    dout_lane;
   logic          dout_last, dout_invalid, dout_valid;
   logic          dout_ready = 1'b0;
`ifdef DISP_SER_STATS_EN
   logic          stat_clr = 1'b0;
   logic [15:0]   stat_invalid_cnt;
`endif

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   disp_serializer #(.DWIDTH(DW)) dut (
      .clk          (clk),
      .rst          (rst),
      .clken        (clken),
      .din_overall  (din_overall),
      .din_valid    (din_valid),
      .din_ready    (din_ready),
      .dout         (dout),
      .dout_lane    (dout_lane),
      .dout_last    (dout_last),
      .dout_invalid (dout_invalid),
      .dout_valid   (dout_valid),
      .dout_ready   (dout_ready)
`ifdef DISP_SER_STATS_EN
      ,
      .stat_clr         (stat_clr),
      .stat_invalid_cnt (stat_invalid_cnt)
`endif
   );

   // Reference model: words held, and how many lanes of the head are already out.
   logic [WW-1:0] mq[$];
   int            midx = 0;
   bit            live = 1'b0;
   int            cyc = 0;
   int            beat_cyc[$];
   int            mcnt = 0;
   bit            mb, mp;
   logic [WW-1:0] mw;
   logic [LW-1:0] ml;

   always @(posedge clk) begin
      cyc++;
      if (rst) begin
         mq.delete();
         midx = 0;
         mcnt = 0;
         live = 1'b1;
      end else if (clken) begin
         mb = (mq.size() > 0) && dout_ready;
         mp = din_valid && (mq.size() < 2);
         if (mb) begin
            mw = mq[0];
            ml = LW'(mw >> (midx * LW));
            beat_cyc.push_back(cyc);
`ifdef DISP_SER_STATS_EN
            if (!stat_clr && (ml[LW-1] || ml[LW-2]) && mcnt < 65535) mcnt++;
`endif
            if (midx == 2) begin
               void'(mq.pop_front());
               midx = 0;
            end else begin
               midx++;
            end
         end
`ifdef DISP_SER_STATS_EN
         if (stat_clr) mcnt = 0;
`endif
         if (mp) mq.push_back(din_overall);
      end
   end

   bit            seen_full = 1'b0;
   bit            tog = 1'b0;
   logic          ev, er, elast, einv;
   logic [LW-1:0] ed;
   logic [1:0]    el;
   logic [WW-1:0] ew;

   task automatic cmp_model();
      if (!live) return;
      ev = (mq.size() > 0);
      er = (mq.size() < 2);
      ew = ev ? mq[0] : '0;
      ed = ev ? LW'(ew >> (midx * LW)) : '0;
      el = 2'(midx);
      elast = (midx == 2);
      einv = ed[LW-1] | ed[LW-2];
      n_cmp++;
      if (dout_valid !== ev || din_ready !== er || dout !== ed || dout_lane !== el ||
          dout_last !== elast || dout_invalid !== einv) begin
         n_err++;
         $display("FAIL model cyc=%0d: got v%b r%b d%h ln%0d lst%b inv%b, want v%b r%b d%h ln%0d lst%b inv%b",
                  cyc, dout_valid, din_ready, dout, dout_lane, dout_last, dout_invalid,
                  ev, er, ed, el, elast, einv);
      end
`ifdef DISP_SER_STATS_EN
      n_cmp++;
      if (stat_invalid_cnt !== 16'(mcnt)) begin
         n_err++;
         $display("FAIL stat_model cyc=%0d: got %h want %h", cyc, stat_invalid_cnt, 16'(mcnt));
      end
`endif
      if (!din_ready) seen_full = 1'b1;
   endtask

   task automatic step();
      @(negedge clk);
      cmp_model();
      if (tog) clken = ~clken;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic send(input logic [WW-1:0] w);
      int  t;
      bit  acc;
      t = 0;
      din_overall = w;
      din_valid   = 1'b1;
      do begin
         acc = din_ready && clken;
         step();
         t++;
      end while (!acc && t < 200);
      if (!acc) chk("send_timeout", 32'd0, 32'd1);
      din_valid = 1'b0;
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (mq.size() > 0 && t < 500) begin
         step();
         t++;
      end
      if (t >= 500) chk("drain_timeout", 32'd0, 32'd1);
   endtask

   logic [WW-1:0] w4 [4];
   int            b0;

   initial begin
      w4[0] = {9'h003, 9'h002, 9'h001};
      w4[1] = {9'h106, 9'h005, 9'h004};
      w4[2] = {9'h009, 9'h088, 9'h007};
      w4[3] = {9'h1FF, 9'h0C0, 9'h000};

      // Reset state
      step();
      step();
      chk("rst_valid", 32'(dout_valid), 32'd0);
      chk("rst_ready", 32'(din_ready), 32'd1);
      chk("rst_lane",  32'(dout_lane), 32'd0);
      chk("rst_last",  32'(dout_last), 32'd0);
      chk("rst_dout",  32'(dout), 32'd0);
      chk("rst_inv",   32'(dout_invalid), 32'd0);
      rst = 1'b0;
      dout_ready = 1'b1;
      step();

      // Single word: lanes 033 / 0AA / 105; 0AA has its occlusion bit set
      send({9'h105, 9'h0AA, 9'h033});
      chk("w1_d0",   32'(dout), 32'h033);
      chk("w1_l0",   32'(dout_lane), 32'd0);
      chk("w1_lst0", 32'(dout_last), 32'd0);
      chk("w1_inv0", 32'(dout_invalid), 32'd0);
      step();
      chk("w1_d1",   32'(dout), 32'h0AA);
      chk("w1_l1",   32'(dout_lane), 32'd1);
      chk("w1_lst1", 32'(dout_last), 32'd0);
      chk("w1_inv1", 32'(dout_invalid), 32'd1);
      step();
      chk("w1_d2",   32'(dout), 32'h105);
      chk("w1_l2",   32'(dout_lane), 32'd2);
      chk("w1_lst2", 32'(dout_last), 32'd1);
      chk("w1_inv2", 32'(dout_invalid), 32'd1);
      step();
      chk("w1_empty", 32'(dout_valid), 32'd0);

      // Four back-to-back words: twelve beats with no bubble
      seen_full = 1'b0;
      b0 = beat_cyc.size();
      for (int k = 0; k < 4; k++) send(w4[k]);
      drain();
      chk("b2b_beats", 32'(beat_cyc.size() - b0), 32'd12);
      if (beat_cyc.size() - b0 >= 12)
         chk("b2b_span", 32'(beat_cyc[b0 + 11] - beat_cyc[b0]), 32'd11);
      chk("b2b_full_seen", 32'(seen_full), 32'd1);

      // Backpressure with two words held
      dout_ready = 1'b0;
      send(w4[1]);
      send(w4[2]);
      chk("bp_ready", 32'(din_ready), 32'd0);
      chk("bp_d",     32'(dout), 32'h004);
      repeat (3) step();
      chk("bp_hold_d",    32'(dout), 32'h004);
      chk("bp_hold_lane", 32'(dout_lane), 32'd0);
      chk("bp_hold_v",    32'(dout_valid), 32'd1);
      dout_ready = 1'b1;
      step();
      chk("bp_rel1", 32'(dout), 32'h005);
      step();
      chk("bp_rel2", 32'(dout), 32'h106);
      step();
      chk("bp_rel3", 32'(dout), 32'h007);
      chk("bp_rel3_lane", 32'(dout_lane), 32'd0);
      drain();

      // clken toggling every cycle: same sequence at half rate
      b0 = beat_cyc.size();
      tog = 1'b1;
      for (int k = 0; k < 3; k++) send(w4[k]);
      drain();
      tog = 1'b0;
      clken = 1'b1;
      chk("ce_beats", 32'(beat_cyc.size() - b0), 32'd9);
      if (beat_cyc.size() - b0 >= 9)
         chk("ce_span", 32'(beat_cyc[b0 + 8] - beat_cyc[b0]), 32'd16);
      step();

      // Reset after the lane-1 beat discards the partial word
      send(w4[3]);
      chk("mr_l0", 32'(dout_lane), 32'd0);
      step();
      step();
      chk("mr_l2", 32'(dout_lane), 32'd2);
      rst = 1'b1;
      step();
      chk("mr_valid", 32'(dout_valid), 32'd0);
      chk("mr_ready", 32'(din_ready), 32'd1);
      chk("mr_lane",  32'(dout_lane), 32'd0);
      rst = 1'b0;
      send(w4[0]);
      chk("mr_new_d",    32'(dout), 32'h001);
      chk("mr_new_lane", 32'(dout_lane), 32'd0);
      drain();

`ifdef DISP_SER_STATS_EN
      // Saturating invalid-lane counter, then clear alongside a flagged beat
      rst = 1'b1;
      step();
      rst = 1'b0;
      din_overall = {9'h101, 9'h102, 9'h103};
      din_valid = 1'b1;
      repeat (70010) step();
      chk("stat_sat", 32'(stat_invalid_cnt), 32'h0000FFFF);
      stat_clr = 1'b1;
      step();
      stat_clr = 1'b0;
      chk("stat_clr", 32'(stat_invalid_cnt), 32'd0);
      din_valid = 1'b0;
      drain();
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

endmodule
